// File: rtl/cpu_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package cpu_fetch_stage_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;

   // addi x0, x0, 0 -- the canonical RV32I no-op used for pipeline bubbles.
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/cpu_fetch_stage_if_id_pipe_reg.sv
// IF/ID pipeline register: flush beats stall beats load. A load with d_valid=0
// inserts a bubble. The same structure is meant to be reused for ID/EX.
module cpu_if_id_pipe_reg
   import cpu_fetch_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            d_valid,
   input  logic [31:0]     d_instr,
   input  logic [XLEN-1:0] d_pc,
   input  logic [XLEN-1:0] d_pc_plus4,
   output logic            q_valid,
   output logic [31:0]     q_instr,
   output logic [XLEN-1:0] q_pc,
   output logic [XLEN-1:0] q_pc_plus4
);

   // Reset and flush both leave a bubble; stall holds; otherwise capture or bubble.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         q_valid    <= 1'b0;
         q_instr    <= NOP_INSTR;
         q_pc       <= '0;
         q_pc_plus4 <= '0;
      end else if (!stall) begin
         if (d_valid) begin
            q_valid    <= 1'b1;
            q_instr    <= d_instr;
            q_pc       <= d_pc;
            q_pc_plus4 <= d_pc_plus4;
         end else begin
            q_valid    <= 1'b0;
            q_instr    <= NOP_INSTR;
            q_pc       <= '0;
            q_pc_plus4 <= '0;
         end
      end
   end

endmodule

// File: rtl/cpu_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, runs the req/ack imem port,
// parks responses that arrive under stall in a one-entry skid buffer, and
// feeds the IF/ID register.
module cpu_fetch_stage
   import cpu_fetch_stage_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_f,
   input  logic            flush_d,
   input  logic            pc_redirect_en,
   input  logic [XLEN-1:0] pc_redirect_addr,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic            id_valid
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

   fetch_state_t    state, state_next;
   logic [XLEN-1:0] pc, pc_next, pc_plus4;
   logic [XLEN-1:0] fetch_addr, fetch_addr_next;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     skid_instr;
   logic [XLEN-1:0] skid_pc;
   logic            skid_load;
   logic            ld_valid;
   logic [31:0]     ld_instr;
   logic [XLEN-1:0] ld_pc, ld_pc_plus4;

   assign pc_plus4    = pc + PC_STEP;
   assign redirect_pc = word_align(pc_redirect_addr);

   // Control state: FSM state, PC and the address held stable while discarding.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         fetch_addr <= RESET_PC;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         fetch_addr <= fetch_addr_next;
      end
   end

   // Skid buffer data; it is occupied exactly while the FSM sits in HOLD.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_instr <= imem_rdata;
         skid_pc    <= pc;
      end
   end

   // Next-state, PC update, memory request and IF/ID load selection.
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      fetch_addr_next = fetch_addr;
      skid_load       = 1'b0;
      imem_req        = 1'b0;
      imem_addr       = pc;
      ld_valid        = 1'b0;
      ld_instr        = imem_rdata;
      ld_pc           = pc;
      ld_pc_plus4     = pc_plus4;
      case (state)
         IDLE: begin
            state_next = FETCH;
            if (pc_redirect_en) pc_next = redirect_pc;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (pc_redirect_en) begin
                  pc_next = redirect_pc;
               end else if (stall_f) begin
                  skid_load  = 1'b1;
                  pc_next    = pc_plus4;
                  state_next = HOLD;
               end else begin
                  ld_valid = 1'b1;
                  pc_next  = pc_plus4;
               end
            end else if (pc_redirect_en) begin
               // The outstanding request must still be seen through at its old address.
               pc_next         = redirect_pc;
               fetch_addr_next = pc;
               state_next      = DISCARD;
            end
         end
         HOLD: begin
            if (pc_redirect_en) begin
               pc_next    = redirect_pc;
               state_next = FETCH;
            end else if (!stall_f) begin
               ld_valid    = 1'b1;
               ld_instr    = skid_instr;
               ld_pc       = skid_pc;
               ld_pc_plus4 = skid_pc + PC_STEP;
               state_next  = FETCH;
            end
         end
         DISCARD: begin
            imem_req  = 1'b1;
            imem_addr = fetch_addr;
            if (pc_redirect_en) pc_next = redirect_pc;
            if (imem_ack) state_next = FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   cpu_if_id_pipe_reg #(
      .XLEN(XLEN)
   ) u_if_id (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall_f),
      .flush     (flush_d),
      .d_valid   (ld_valid),
      .d_instr   (ld_instr),
      .d_pc      (ld_pc),
      .d_pc_plus4(ld_pc_plus4),
      .q_valid   (id_valid),
      .q_instr   (id_instr),
      .q_pc      (id_pc),
      .q_pc_plus4(id_pc_plus4)
   );

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Bench for cpu_fetch_stage: cycle-exact vector table and hand sequences for the
// corner cases, then a randomized stall / wait-state run checked by a scoreboard.
module tb_cpu_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_f, flush_d, pc_redirect_en;
   logic [31:0] pc_redirect_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] id_instr, id_pc, id_pc_plus4;
   logic        id_valid;

   always #5 clk = ~clk;

   cpu_fetch_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_f         (stall_f),
      .flush_d         (flush_d),
      .pc_redirect_en  (pc_redirect_en),
      .pc_redirect_addr(pc_redirect_addr),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .id_instr        (id_instr),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4),
      .id_valid        (id_valid)
   );

   int n_cmp = 0;
   int n_err = 0;

   // bench memory model
   logic mem_const = 1'b1;
   int   mem_wait  = 0;
   int   wait_cnt  = 0;
   logic force_ack = 1'b0;

   // what was applied at the most recent edge
   logic last_rst, last_stall, last_flush;

   // scoreboard
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;
   sb_t         sbq[$];
   logic        sb_on   = 1'b0;
   logic [31:0] sb_addr = 32'h0;
   int          sb_pops = 0;

   typedef struct {
      logic        stall;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;
   vec_t vt[6];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_const) return 32'h00A0_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
      end
   endtask

   task automatic chk1(input string tag, input string what, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %b expected %b", tag, what, act, exp);
      end
   endtask

   task automatic drive_mem();
      if (force_ack) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_req === 1'b1 && wait_cnt >= mem_wait) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 32'h0;
      end
   endtask

   // One clock: respond from memory, advance, then check request stability.
   task automatic cycle();
      logic        pre_req, pre_ack, pre_rst;
      logic [31:0] pre_addr;
      sb_t         e;
      drive_mem();
      #1;
      pre_req    = (imem_req === 1'b1);
      pre_ack    = imem_ack;
      pre_addr   = imem_addr;
      pre_rst    = rst_n;
      last_rst   = rst_n;
      last_stall = stall_f;
      last_flush = flush_d;
      if (pre_req && pre_ack) begin
         wait_cnt = 0;
         if (sb_on && pre_rst) begin
            chk("sb", "ack_addr", pre_addr, sb_addr);
            e.pc    = sb_addr;
            e.instr = mem_word(sb_addr);
            sbq.push_back(e);
            sb_addr  = sb_addr + 32'd4;
            mem_wait = int'($urandom_range(0, 2));
         end
      end else if (pre_req) begin
         wait_cnt++;
      end else begin
         wait_cnt = 0;
      end
      @(posedge clk);
      #1;
      if (!pre_rst) wait_cnt = 0;
      if (pre_rst && pre_req && !pre_ack) begin
         chk1("stable", "req", imem_req, 1'b1);
         chk("stable", "addr", imem_addr, pre_addr);
      end
   endtask

   task automatic expect_state(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc);
      chk1(tag, "imem_req", imem_req, e_req);
      if (e_req) chk(tag, "imem_addr", imem_addr, e_addr);
      chk1(tag, "id_valid", id_valid, e_valid);
      if (e_valid) begin
         chk(tag, "id_pc", id_pc, e_pc);
         chk(tag, "id_pc_plus4", id_pc_plus4, e_pc + 32'd4);
         chk(tag, "id_instr", id_instr, mem_word(e_pc));
      end else begin
         chk(tag, "id_instr", id_instr, NOP);
      end
   endtask

   task automatic step(input string tag, input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc);
      expect_state(tag, e_req, e_addr, e_valid, e_pc);
      cycle();
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      stall_f          = 1'b0;
      flush_d          = 1'b0;
      pc_redirect_en   = 1'b0;
      pc_redirect_addr = 32'h0;
      force_ack        = 1'b0;
      mem_wait         = 0;
      repeat (2) cycle();
   endtask

   task automatic expect_reset(input string tag);
      chk1(tag, "imem_req", imem_req, 1'b0);
      chk1(tag, "id_valid", id_valid, 1'b0);
      chk(tag, "id_instr", id_instr, NOP);
      chk(tag, "id_pc", id_pc, 32'h0);
      chk(tag, "id_pc_plus4", id_pc_plus4, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;

      // zero-wait sequential fetch, constant memory word
      vt[0] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
      vt[1] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
      vt[2] = '{1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
      vt[3] = '{1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
      vt[4] = '{1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
      vt[5] = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};

      do_reset();
      expect_reset("reset");
      rst_n     = 1'b1;
      mem_const = 1'b1;
      for (int i = 0; i < 6; i++) begin
         stall_f = vt[i].stall;
         step($sformatf("t1_row%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid, vt[i].e_pc);
      end

      // two wait states on the fetch of 0x8
      do_reset();
      rst_n     = 1'b1;
      mem_const = 1'b0;
      step("t2c0", 0, 32'h0, 0, 32'h0);
      step("t2c1", 1, 32'h0, 0, 32'h0);
      step("t2c2", 1, 32'h4, 1, 32'h0);
      mem_wait = 2;
      step("t2c3", 1, 32'h8, 1, 32'h4);
      step("t2c4", 1, 32'h8, 0, 32'h0);
      step("t2c5", 1, 32'h8, 0, 32'h0);
      mem_wait = 0;
      step("t2c6", 1, 32'hC, 1, 32'h8);

      // ack of 0x10 under a three-cycle stall goes through the skid buffer
      do_reset();
      rst_n = 1'b1;
      step("t3c0", 0, 32'h0, 0, 32'h0);
      step("t3c1", 1, 32'h0, 0, 32'h0);
      step("t3c2", 1, 32'h4, 1, 32'h0);
      step("t3c3", 1, 32'h8, 1, 32'h4);
      step("t3c4", 1, 32'hC, 1, 32'h8);
      stall_f = 1'b1;
      step("t3c5", 1, 32'h10, 1, 32'hC);
      step("t3c6", 0, 32'h0, 1, 32'hC);
      step("t3c7", 0, 32'h0, 1, 32'hC);
      stall_f = 1'b0;
      step("t3c8", 0, 32'h0, 1, 32'hC);
      step("t3c9", 1, 32'h14, 1, 32'h10);
      step("t3c10", 1, 32'h18, 1, 32'h14);

      // redirect to 0x100 while 0x20 is still waiting for its ack
      step("t4c11", 1, 32'h1C, 1, 32'h18);
      mem_wait         = 2;
      pc_redirect_en   = 1'b1;
      pc_redirect_addr = 32'h0000_0100;
      step("t4c12", 1, 32'h20, 1, 32'h1C);
      pc_redirect_en = 1'b0;
      step("t4c13", 1, 32'h20, 0, 32'h0);
      step("t4c14", 1, 32'h20, 0, 32'h0);
      mem_wait = 0;
      step("t4c15", 1, 32'h100, 0, 32'h0);

      // flush and stall together with a valid instruction in IF/ID
      mem_wait = 2;
      flush_d  = 1'b1;
      stall_f  = 1'b1;
      step("t5c16", 1, 32'h104, 1, 32'h100);
      flush_d = 1'b0;
      stall_f = 1'b0;
      step("t5c17", 1, 32'h104, 0, 32'h0);
      step("t5c18", 1, 32'h104, 0, 32'h0);
      mem_wait = 0;

      // misaligned redirect near the top of memory, wrap of pc+4
      pc_redirect_en   = 1'b1;
      pc_redirect_addr = 32'hFFFF_FFFE;
      step("t6c19", 1, 32'h108, 1, 32'h104);
      pc_redirect_en = 1'b0;
      step("t6c20", 1, 32'hFFFF_FFFC, 0, 32'h0);
      step("t6c21", 1, 32'h0, 1, 32'hFFFF_FFFC);

      // reset in the middle of a waiting request; the late ack must be ignored
      mem_wait = 3;
      rst_n    = 1'b0;
      step("t6c22", 1, 32'h4, 1, 32'h0);
      expect_reset("t6c23_rst");
      rst_n     = 1'b1;
      force_ack = 1'b1;
      cycle();
      force_ack = 1'b0;
      mem_wait  = 0;
      step("t6c24", 1, 32'h0, 0, 32'h0);
      step("t6c25", 1, 32'h4, 1, 32'h0);

      // random stalls and wait states; every address must reach ID once, in order
      do_reset();
      rst_n   = 1'b1;
      sb_addr = 32'h0;
      sb_on   = 1'b1;
      for (int i = 0; i < 400; i++) begin
         stall_f = (i < 390) ? ($urandom_range(0, 99) < 30) : 1'b0;
         cycle();
         if (last_rst && !last_stall && !last_flush && id_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb.underflow: id_pc %h valid with nothing expected", id_pc);
            end else begin
               sb_t e;
               e = sbq.pop_front();
               sb_pops++;
               chk("sb", "id_pc", id_pc, e.pc);
               chk("sb", "id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
               chk("sb", "id_instr", id_instr, e.instr);
            end
         end
      end
      chk("sb", "leftover", 32'(sbq.size()), 32'd0);
      chk1("sb", "enough_traffic", sb_pops > 100, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_fetch_stage.md
Name: cpu_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I CPU. It sits directly upstream of the decode stage.
- Owns the PC and drives a req/ack instruction-memory port.
- Holds the IF/ID pipeline register, whose instruction output feeds decode (opc/funct3/funct7 slicing).
- Supports stall and flush from the hazard unit, PC redirect from EX (taken branch/jump), and a one-entry skid buffer for memory responses that arrive while stalled.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  CPU clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- stall_f  in  1  hazard unit: hold PC and IF/ID contents.
- flush_d  in  1  hazard unit: load a bubble into IF/ID.
- pc_redirect_en  in  1  EX stage: branch taken or jump.
- pc_redirect_addr  in  XLEN  redirect target; bits [1:0] ignored and treated as 00.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address; word aligned.
- imem_ack  in  1  memory: imem_rdata valid this cycle; may be asserted in the same cycle as req (zero wait).
- imem_rdata  in  32  fetched instruction word.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  XLEN  IF/ID PC of the instruction.
- id_pc_plus4  out  XLEN  IF/ID PC+4.
- id_valid  out  1  IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC, state=IDLE, skid buffer empty.
  - id_valid=0, id_instr=NOP (32'h0000_0013), id_pc=0, id_pc_plus4=0.
  - imem_req=0 during reset and in the cycle after; no response is ever expected across reset.
  - A reset that lands mid-request abandons that request; any late ack is ignored while in IDLE.
- FSM states: IDLE, FETCH, HOLD, DISCARD.
- IDLE: imem_req=0. Next state is FETCH. First request is issued the cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Once asserted, req and addr must stay stable until ack.
  - Ack, no redirect, no stall: IF/ID <- {imem_rdata, pc, pc+4, valid=1}; pc <- pc+4; stay in FETCH.
  - Sustained throughput is 1 instruction per cycle with zero-wait memory.
  - Ack with stall_f=1, no redirect: rdata/pc go to the skid buffer; pc <- pc+4; go to HOLD.
  - No ack, not stalled: IF/ID loads a bubble (valid=0, NOP).
  - No ack, stalled: IF/ID holds.
- HOLD:
  - imem_req=0.
  - When stall_f drops, the buffer moves to IF/ID (valid=1); go to FETCH.
  - IF/ID holds while stall_f=1.
- DISCARD:
  - imem_req=1 at the old address until ack.
  - On ack, drop the data and go to FETCH at the redirect target, which is latched in pc.
  - IF/ID loads bubbles unless stalled.
- Redirect (pc_redirect_en=1) has priority over stall_f for PC state:
  - In FETCH with ack this cycle: drop rdata; pc <- target; stay in FETCH.
  - In FETCH without ack: pc <- target; go to DISCARD.
  - In HOLD: empty the buffer; pc <- target; go to FETCH.
  - In DISCARD: pc <- the newer target.
  - In IDLE: pc <- target.
- IF/ID update priority: flush_d > stall_f > load.
  - Flush loads the bubble even when stall_f=1.
  - Flush does not affect the skid buffer or PC.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no flag.
- Outputs id_* come directly from flops. There is no combinational path from imem_rdata to id_instr.

Decomposition:
- pkg_cpu_typedefs additions:
  - fetch_state_t enum {IDLE, FETCH, HOLD, DISCARD}.
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default constant.
- Sub-module cpu_if_id_pipe_reg: flop bank with stall/flush/load priority and sync active-low reset. The same structure is reused later for ID/EX.

Test Plan:
1. Reset release with zero-wait memory returning instr = 32'h00A00093 at every address -> first imem_req at cycle 1 with addr 0x0. Cycle 2: id_valid=1, id_pc=0x0, id_pc_plus4=0x4. Thereafter id_pc increments by 4 every cycle.
2. Memory with 2 wait states -> imem_addr stable at 0x8 for 3 cycles. id_valid=0 (NOP) for 2 cycles, then id_instr=word@0x8, id_pc=0x8.
3. stall_f=1 for 3 cycles while ack arrives for 0x10 -> imem_req drops during HOLD and IF/ID unchanged. After stall release, id_pc=0x10 the next cycle and the next fetch is 0x14.
4. Redirect to 0x100 while the request to 0x20 is waiting for ack (ack 2 cycles later) -> req stays on 0x20 until ack, data discarded. The next request is 0x100, and id_pc=0x100 appears with no 0x20 instruction ever valid.
5. flush_d and stall_f asserted together with id_valid=1 -> next cycle id_valid=0, id_instr=NOP; PC unchanged.
6. Redirect to 0xFFFF_FFFE, then sequential fetch -> imem_addr=0xFFFF_FFFC, then 0x0 (wrap). Also assert rst_n=0 mid-wait -> all id_* reset values next edge and a late ack is ignored.
